// File: rtl/seeg_framer_pkg.sv
// seeg_framer_pkg: shared FSM state type, header constants and header packing for the batch framer.
package seeg_framer_pkg;
    typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD, TRAILER} state_t;
    localparam logic [15:0] HDR_MAGIC_DEF = 16'hEE61;
    localparam int BATCH_W = 16;
    function automatic logic [31:0] pack_hdr(input logic [15:0] magic, input logic [15:0] seq);
        return {magic, seq};
    endfunction
endpackage

// File: rtl/seeg_axis_fifo.sv
// seeg_axis_fifo: first-word-fall-through FIFO with occupancy count; push when full and pop when empty are ignored.
module seeg_axis_fifo #(
    parameter int W = 32,
    parameter int DEPTH = 4096,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_push,
    input  logic [W-1:0]  i_din,
    input  logic          i_pop,
    output logic [W-1:0]  o_dout,
    output logic          o_full,
    output logic          o_empty,
    output logic [CW-1:0] o_count
);
    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wp, r_rp;
    logic [CW-1:0] r_count;
    logic          w_push, w_pop;
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_full  = r_count == CW'(DEPTH);
    assign o_empty = r_count == '0;
    assign o_count = r_count;
    assign o_dout  = r_mem[r_rp];
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wp] <= i_din;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else begin
            r_wp    <= r_wp + AW'(w_push);
            r_rp    <= r_rp + AW'(w_pop);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end
endmodule

// File: rtl/seeg_axis_batch_framer.sv
// seeg_axis_batch_framer: store-and-forward packer turning the sample stream into header+payload DMA frames.
// Defining SEEG_FRAMER_CSUM_EN appends a mod-2^32 payload-sum trailer word carrying TLAST.
module seeg_axis_batch_framer
    import seeg_framer_pkg::*;
#(
    parameter int          DATA_W     = 32,
    parameter int          FIFO_DEPTH = 4096,
    parameter logic [15:0] HDR_MAGIC  = HDR_MAGIC_DEF
) (
    input  logic               AXIS_ACLK,
    input  logic               AXIS_ARESETN,
    input  logic               enable,
    input  logic [BATCH_W-1:0] batch_size,
    input  logic [DATA_W-1:0]  S_AXIS_tdata,
    input  logic               S_AXIS_tvalid,
    output logic               S_AXIS_tready,
    output logic [DATA_W-1:0]  M_AXIS_tdata,
    output logic               M_AXIS_tvalid,
    input  logic               M_AXIS_tready,
    output logic               M_AXIS_tlast,
    output logic [15:0]        seq_num,
    output logic [15:0]        overflow_cnt,
    output logic               busy
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
`ifdef SEEG_FRAMER_CSUM_EN
    localparam bit LAST_ON_PAYLOAD = 1'b0;
`else
    localparam bit LAST_ON_PAYLOAD = 1'b1;
`endif
    state_t            r_state, w_nstate;
    logic [DATA_W-1:0] r_tdata, w_tdata, w_dout;
    logic              r_tvalid, w_tvalid, r_tlast, w_tlast;
    logic [CW-1:0]     r_len, w_len, r_cnt, w_cnt, w_count, w_eff;
    logic [15:0]       r_seq, r_ovf;
    logic              r_rdy, r_en_d, r_flush, r_clr_pend;
    logic              w_push, w_drop, w_pop, w_full, w_empty, w_seq_inc;
    logic              w_start, w_rise, w_fall, w_idle_empty, w_clr;
    seeg_axis_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (AXIS_ACLK),
        .rst_n   (AXIS_ARESETN),
        .i_push  (w_push),
        .i_din   (S_AXIS_tdata),
        .i_pop   (w_pop),
        .o_dout  (w_dout),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );
    // The source is never stalled: anything that does not fit is dropped and counted.
    assign w_push       = r_rdy && S_AXIS_tvalid && enable && !w_full;
    assign w_drop       = r_rdy && S_AXIS_tvalid && enable && w_full;
    assign w_rise       = enable && !r_en_d;
    assign w_fall       = !enable && r_en_d;
    assign w_idle_empty = (r_state == IDLE) && w_empty;
    assign w_clr        = (w_rise || r_clr_pend) && w_idle_empty;
    assign w_eff        = (batch_size == '0) ? CW'(1)
                        : ({16'd0, batch_size} >= 32'(FIFO_DEPTH)) ? CW'(FIFO_DEPTH) : CW'(batch_size);
    assign w_start      = (w_count >= w_eff) || (r_flush && !w_empty);
    assign S_AXIS_tready = r_rdy;
    assign M_AXIS_tdata  = r_tdata;
    assign M_AXIS_tvalid = r_tvalid;
    assign M_AXIS_tlast  = r_tlast;
    assign seq_num       = r_seq;
    assign overflow_cnt  = r_ovf;
    assign busy          = (r_state != IDLE) || !w_empty;
`ifdef SEEG_FRAMER_CSUM_EN
    logic [DATA_W-1:0] r_sum;
    always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
        if (!AXIS_ARESETN) r_sum <= '0;
        else if (w_pop) r_sum <= ((r_state == HEADER) ? '0 : r_sum) + w_dout;
    end
`endif
    // Output stage is a register; a FIFO word is popped exactly when it is loaded into it.
    always_comb begin
        w_nstate  = r_state;
        w_tvalid  = r_tvalid;
        w_tlast   = r_tlast;
        w_tdata   = r_tdata;
        w_len     = r_len;
        w_cnt     = r_cnt;
        w_pop     = 1'b0;
        w_seq_inc = 1'b0;
        case (r_state)
            IDLE: if (w_start) begin
                w_len    = (w_count < w_eff) ? w_count : w_eff;
                w_tvalid = 1'b1;
                w_tlast  = 1'b0;
                w_tdata  = pack_hdr(HDR_MAGIC, r_seq);
                w_nstate = HEADER;
            end
            HEADER: if (M_AXIS_tready) begin
                w_seq_inc = 1'b1;
                w_pop     = 1'b1;
                w_tdata   = w_dout;
                w_cnt     = CW'(1);
                w_tlast   = LAST_ON_PAYLOAD && (r_len == CW'(1));
                w_nstate  = PAYLOAD;
            end
            PAYLOAD: if (M_AXIS_tready) begin
                if (r_cnt != r_len) begin
                    w_pop   = 1'b1;
                    w_tdata = w_dout;
                    w_cnt   = r_cnt + CW'(1);
                    w_tlast = LAST_ON_PAYLOAD && (w_cnt == r_len);
                end else begin
`ifdef SEEG_FRAMER_CSUM_EN
                    w_tdata  = r_sum;
                    w_tlast  = 1'b1;
                    w_nstate = TRAILER;
`else
                    w_tvalid = 1'b0;
                    w_tlast  = 1'b0;
                    w_nstate = IDLE;
`endif
                end
            end
`ifdef SEEG_FRAMER_CSUM_EN
            TRAILER: if (M_AXIS_tready) begin
                w_tvalid = 1'b0;
                w_tlast  = 1'b0;
                w_nstate = IDLE;
            end
`endif
            default: ;
        endcase
    end
    always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
        if (!AXIS_ARESETN) begin
            r_state    <= IDLE;
            r_tvalid   <= 1'b0;
            r_tlast    <= 1'b0;
            r_tdata    <= '0;
            r_len      <= '0;
            r_cnt      <= '0;
            r_seq      <= '0;
            r_ovf      <= '0;
            r_rdy      <= 1'b0;
            r_en_d     <= 1'b0;
            r_flush    <= 1'b0;
            r_clr_pend <= 1'b0;
        end else begin
            r_state    <= w_nstate;
            r_tvalid   <= w_tvalid;
            r_tlast    <= w_tlast;
            r_tdata    <= w_tdata;
            r_len      <= w_len;
            r_cnt      <= w_cnt;
            r_rdy      <= 1'b1;
            r_en_d     <= enable;
            r_flush    <= w_fall || (r_flush && !w_idle_empty);
            r_clr_pend <= (w_rise || r_clr_pend) && !w_clr;
            r_seq      <= w_clr ? '0 : r_seq + 16'(w_seq_inc);
            r_ovf      <= w_clr ? '0 : (w_drop && r_ovf != 16'hFFFF) ? r_ovf + 16'd1 : r_ovf;
        end
    end
endmodule
